// File: rtl/pipelined_instruction_decoder_if.sv
// Handshake bundle between fetch, the instruction decoder and the execution units.
// master = fetch/consumer side driving the decoder, slave = the decoder itself.
interface pipelined_instruction_decoder_if #(
  parameter int INSTR_W   = 32,
  parameter int TYPE_W    = 3,
  parameter int FUNC_W    = 5,
  parameter int REG_W     = 8,
  parameter int ILL_CNT_W = 8,
  parameter int IMM_W     = INSTR_W - TYPE_W - FUNC_W
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instruction;
  logic                 out_valid;
  logic                 out_ready;
  logic [TYPE_W-1:0]    out_type;
  logic [FUNC_W-1:0]    out_func;
  logic [REG_W-1:0]     out_t_reg;
  logic [REG_W-1:0]     out_s_reg;
  logic [REG_W-1:0]     out_f_reg;
  logic [IMM_W-1:0]     out_imm;
  logic                 out_illegal;
  logic                 ill_cnt_clr;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output flush, in_valid, in_instruction, out_ready, ill_cnt_clr,
    input  in_ready, out_valid, out_type, out_func, out_t_reg, out_s_reg,
           out_f_reg, out_imm, out_illegal, ill_count
  );

  modport slave (
    input  flush, in_valid, in_instruction, out_ready, ill_cnt_clr,
    output in_ready, out_valid, out_type, out_func, out_t_reg, out_s_reg,
           out_f_reg, out_imm, out_illegal, ill_count
  );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// Registered instruction decoder with a 2-entry skid buffer and a saturating illegal-word counter.
//
// state | meaning
// EMPTY | no decoded word held, out_valid=0
// ONE   | output register full, skid empty
// FULL  | output register and skid full, in_ready=0
module pipelined_instruction_decoder #(
  parameter int INSTR_W   = 32,
  parameter int TYPE_W    = 3,
  parameter int FUNC_W    = 5,
  parameter int REG_W     = 8,
  parameter logic [(1<<TYPE_W)-1:0] REG_TYPE_MASK = 8'b1001_1110,
  parameter logic [(1<<TYPE_W)-1:0] ILL_TYPE_MASK = 8'b0110_0000,
  parameter int ILL_CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  pipelined_instruction_decoder_if.slave bus
);
  localparam int IMM_W = INSTR_W - TYPE_W - FUNC_W;
  localparam int DEC_W = TYPE_W + FUNC_W + 3*REG_W + IMM_W + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [DEC_W-1:0]     out_q;
  logic [DEC_W-1:0]     skid_q;
  logic [ILL_CNT_W-1:0] ill_count_q;
  logic [ILL_CNT_W-1:0] ill_count_d;

  logic [TYPE_W-1:0]    dec_type;
  logic [FUNC_W-1:0]    dec_func;
  logic [3*REG_W-1:0]   dec_regs;
  logic                 dec_illegal;
  logic [DEC_W-1:0]     dec_d;
  logic                 accept;
  logic                 deliver;

  always_comb begin
    dec_type    = bus.in_instruction[INSTR_W-1 -: TYPE_W];
    dec_func    = bus.in_instruction[INSTR_W-TYPE_W-1 -: FUNC_W];
    dec_regs    = REG_TYPE_MASK[dec_type] ? bus.in_instruction[3*REG_W-1:0] : '0;
    dec_illegal = ILL_TYPE_MASK[dec_type];
    dec_d       = {dec_type, dec_func, dec_regs, bus.in_instruction[IMM_W-1:0], dec_illegal};
  end

  assign accept  = bus.in_valid & in_ready_q & ~bus.flush;
  assign deliver = out_valid_q & bus.out_ready;

  // A flushed cycle still lets a same-cycle deliver complete; only buffered state is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_q       <= dec_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            out_q <= dec_d;
          end else if (accept) begin
            skid_q     <= dec_d;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (deliver) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ill_count_d = ill_count_q;
    if (bus.ill_cnt_clr)
      ill_count_d = '0;
    else if (accept && dec_illegal && (ill_count_q != {ILL_CNT_W{1'b1}}))
      ill_count_d = ill_count_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_count_q <= '0;
    else
      ill_count_q <= ill_count_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ill_count = ill_count_q;
  assign {bus.out_type, bus.out_func, bus.out_t_reg, bus.out_s_reg,
          bus.out_f_reg, bus.out_imm, bus.out_illegal} = out_q;
endmodule
